// File: rtl/fpu_sched_pkg.sv
// -----------------------------------------------------------------------------
// fpu_sched_pkg
// Shared definitions for the FP64 request scheduler:
//   - state_e   : scheduler FSM state encoding (also driven on dbg_state)
//   - MODE_*    : 3-bit FP unit op codes
//   - FP_W      : operand/result width
//   - MODE_W    : op code width
// -----------------------------------------------------------------------------
package fpu_sched_pkg;

   localparam int FP_W   = 64;
   localparam int MODE_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [MODE_W-1:0] MODE_ADD  = 3'd0;
   localparam logic [MODE_W-1:0] MODE_SUB  = 3'd1;
   localparam logic [MODE_W-1:0] MODE_MUL  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_DIV  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_SIN  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_COS  = 3'd5;
   localparam logic [MODE_W-1:0] MODE_SQRT = 3'd6;
   localparam logic [MODE_W-1:0] MODE_LN   = 3'd7;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_rr_arbiter
// Purely combinational round-robin selector. The search starts at index ptr
// and ascends, wrapping from NUM_REQ-1 to 0; the first asserted request wins.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    priority pointer (must be < NUM_REQ)
//   grant  out NUM_REQ  one-hot grant (all zero when no request)
//   winner out IDX_W    index of the granted request (0 when none)
//   any    out 1        at least one request present
// -----------------------------------------------------------------------------
module fpu_rr_arbiter
   import fpu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      // Rotate the search origin to ptr; 'any' doubles as the found flag so
      // only the first hit in rotated order is granted.
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
            any                                 = 1'b1;
            winner                              = IDX_W'((int'(ptr) + k) % NUM_REQ);
            grant[(int'(ptr) + k) % NUM_REQ]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_scheduler.sv
// -----------------------------------------------------------------------------
// fpu_scheduler
// Shares one multi-cycle FP64 unit among NUM_REQ requesters. One transaction is
// in flight at a time: IDLE (arbitrate/accept) -> ISSUE (start pulse) ->
// WAIT (until fpu_done) -> RESP (one-cycle response strobe) -> IDLE.
//
// Handshake: a request is taken on a rising edge where req_valid[i] and
// req_ready[i] are both 1. req_ready is one-hot, combinational, and only
// non-zero in IDLE. rsp_valid is a one-cycle, one-hot strobe to the owner with
// rsp_data/rsp_err qualified by it; there is no back-pressure on responses.
//
// Optional feature macro: FPU_SCHED_TIMEOUT_EN
//   defined   : WAIT watchdog of TIMEOUT_CYCLES cycles; on expiry respond with
//               rsp_data=0, rsp_err=1. fpu_done wins over a same-cycle expiry.
//   undefined : no counter, WAIT holds until fpu_done, rsp_err tied 0.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready  [NUM_REQ]  request handshake
//   req_mode  [3*NUM_REQ]           per-requester op code
//   req_op1/req_op2 [64*NUM_REQ]    per-requester operands
//   rsp_valid [NUM_REQ]             one-hot response strobe
//   rsp_data  [64], rsp_err         response payload / timeout flag
//   fpu_enable                      one-cycle start pulse to the FP unit
//   fpu_mode [3], fpu_op1/op2 [64]  held operands to the FP unit
//   fpu_result [64], fpu_done       FP unit result and completion pulse
//   busy                            high in every state except IDLE
//   dbg_state [2]                   current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module fpu_scheduler
   import fpu_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [3*NUM_REQ-1:0]    req_mode,
   input  logic [64*NUM_REQ-1:0]   req_op1,
   input  logic [64*NUM_REQ-1:0]   req_op2,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [63:0]             rsp_data,
   output logic                    rsp_err,
   output logic                    fpu_enable,
   output logic [2:0]              fpu_mode,
   output logic [63:0]             fpu_op1,
   output logic [63:0]             fpu_op2,
   input  logic [63:0]             fpu_result,
   input  logic                    fpu_done,
   output logic                    busy,
   output logic [1:0]              dbg_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("fpu_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    winner_q, winner_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [FP_W-1:0]     op1_q, op1_d;
   logic [FP_W-1:0]     op2_q, op2_d;
   logic [FP_W-1:0]     rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]    arb_winner;
   logic                arb_any;

`ifdef FPU_SCHED_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rsp_err_q, rsp_err_d;
`endif

   fpu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .grant   (arb_grant),
      .winner  (arb_winner),
      .any     (arb_any)
   );

   // Next-state and datapath capture.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      winner_d   = winner_q;
      mode_d     = mode_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      rsp_data_d = rsp_data_q;
`ifdef FPU_SCHED_TIMEOUT_EN
      cnt_d      = cnt_q;
      rsp_err_d  = rsp_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d  = ST_ISSUE;
               winner_d = arb_winner;
               ptr_d    = (int'(arb_winner) == NUM_REQ - 1) ? '0 : arb_winner + 1'b1;
               mode_d   = req_mode[int'(arb_winner) * MODE_W +: MODE_W];
               op1_d    = req_op1[int'(arb_winner) * FP_W +: FP_W];
               op2_d    = req_op2[int'(arb_winner) * FP_W +: FP_W];
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef FPU_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            // fpu_done is checked first so a completion coinciding with the
            // watchdog limit is reported as a normal result.
            if (fpu_done) begin
               state_d    = ST_RESP;
               rsp_data_d = fpu_result;
`ifdef FPU_SCHED_TIMEOUT_EN
               rsp_err_d  = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // cnt_q counts completed WAIT cycles; this is the last allowed one.
               state_d    = ST_RESP;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end else begin
               cnt_d      = cnt_q + 1'b1;
`endif
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         winner_q   <= '0;
         mode_q     <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         rsp_data_q <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
         cnt_q      <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         winner_q   <= winner_d;
         mode_q     <= mode_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         rsp_data_q <= rsp_data_d;
`ifdef FPU_SCHED_TIMEOUT_EN
         cnt_q      <= cnt_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   // Outputs. req_ready is also gated by rst_n so nothing appears accepted
   // while reset is being applied.
   always_comb begin
      rsp_valid = '0;
      if (state_q == ST_RESP) begin
         rsp_valid[winner_q] = 1'b1;
      end
   end

   assign req_ready  = (state_q == ST_IDLE && rst_n) ? arb_grant : '0;
   assign rsp_data   = rsp_data_q;
   assign fpu_enable = (state_q == ST_ISSUE);
   assign fpu_mode   = mode_q;
   assign fpu_op1    = op1_q;
   assign fpu_op2    = op2_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

`ifdef FPU_SCHED_TIMEOUT_EN
   assign rsp_err    = (state_q == ST_RESP) ? rsp_err_q : 1'b0;
`else
   assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fpu_scheduler
// Directed + randomized bench for fpu_scheduler (NUM_REQ=4). The bench plays the
// FP unit itself: it returns a random result after a chosen latency. Expected
// winners come from a round-robin model over the request vector, expected
// responses from the values the bench handed to the FP unit.
// Timeout cases run only when FPU_SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fpu_scheduler;
   import fpu_sched_pkg::*;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [3*N-1:0]  req_mode = '0;
   logic [64*N-1:0] req_op1 = '0;
   logic [64*N-1:0] req_op2 = '0;
   logic [N-1:0]    rsp_valid;
   logic [63:0]     rsp_data;
   logic            rsp_err;
   logic            fpu_enable;
   logic [2:0]      fpu_mode;
   logic [63:0]     fpu_op1, fpu_op2;
   logic [63:0]     fpu_result = '0;
   logic            fpu_done = 1'b0;
   logic            busy;
   logic [1:0]      dbg_state;

   always #5 clk = ~clk;

   fpu_scheduler #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mode   (req_mode),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .fpu_enable (fpu_enable),
      .fpu_mode   (fpu_mode),
      .fpu_op1    (fpu_op1),
      .fpu_op2    (fpu_op2),
      .fpu_result (fpu_result),
      .fpu_done   (fpu_done),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   int en_cnt = 0;
   int txn_cnt = 0;

   // Requester-side operand storage and model state.
   logic [2:0]  mode_a [N];
   logic [63:0] op1_a  [N];
   logic [63:0] op2_a  [N];
   int          ptr_m;
   int          exp_w;
   logic [2:0]  exp_mode;
   logic [63:0] exp_op1, exp_op2;

   always @(negedge clk) if (fpu_enable === 1'b1) en_cnt++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         req_mode[3*i +: 3]  = mode_a[i];
         req_op1[64*i +: 64] = op1_a[i];
         req_op2[64*i +: 64] = op2_a[i];
      end
   endtask

   task automatic scramble_ops();
      for (int i = 0; i < N; i++) begin
         mode_a[i] = 3'($urandom_range(0, 7));
         op1_a[i]  = {$urandom, $urandom};
         op2_a[i]  = {$urandom, $urandom};
      end
      drive_ops();
   endtask

   // Round-robin reference: first set bit at or after p, wrapping.
   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},  req_ready,  64'd0);
      check({tag, "_rspv"},   rsp_valid,  64'd0);
      check({tag, "_rspd"},   rsp_data,   64'd0);
      check({tag, "_err"},    rsp_err,    64'd0);
      check({tag, "_en"},     fpu_enable, 64'd0);
      check({tag, "_mode"},   fpu_mode,   64'd0);
      check({tag, "_op1"},    fpu_op1,    64'd0);
      check({tag, "_op2"},    fpu_op2,    64'd0);
      check({tag, "_busy"},   busy,       64'd0);
      check({tag, "_state"},  dbg_state,  64'(ST_IDLE));
   endtask

   // From IDLE: present vld, accept, go through ISSUE (with a stray fpu_done,
   // winner drop and operand churn), and leave the DUT in its first WAIT cycle.
   task automatic start_txn(input logic [N-1:0] vld);
      req_valid = vld;
      drive_ops();
      #1;
      exp_w = rr_pick(vld, ptr_m);
      check("idle_ready", req_ready, 64'(1) << exp_w);
      check("idle_busy", busy, 64'd0);
      exp_mode = mode_a[exp_w];
      exp_op1  = op1_a[exp_w];
      exp_op2  = op2_a[exp_w];
      step();
      txn_cnt++;
      ptr_m = (exp_w + 1) % N;
      check("issue_en", fpu_enable, 64'd1);
      check("issue_ready", req_ready, 64'd0);
      check("issue_busy", busy, 64'd1);
      check("issue_mode", fpu_mode, 64'(exp_mode));
      check("issue_op1", fpu_op1, exp_op1);
      check("issue_op2", fpu_op2, exp_op2);
      fpu_done   = 1'b1;
      fpu_result = {$urandom, $urandom};
      req_valid[exp_w] = 1'b0;
      scramble_ops();
      step();
      fpu_done = 1'b0;
      check("wait_state", dbg_state, 64'(ST_WAIT));
      check("wait_rspv", rsp_valid, 64'd0);
      check("wait_en", fpu_enable, 64'd0);
      check("wait_op1_hold", fpu_op1, exp_op1);
   endtask

   // From the first WAIT cycle: lat more WAIT cycles, then fpu_done with r.
   task automatic finish_txn(input int lat, input logic [63:0] r);
      for (int k = 0; k < lat; k++) begin
         step();
         check("wait_rspv_lat", rsp_valid, 64'd0);
         check("wait_op2_hold", fpu_op2, exp_op2);
      end
      fpu_done   = 1'b1;
      fpu_result = r;
      step();
      fpu_done   = 1'b0;
      fpu_result = {$urandom, $urandom};
      check("resp_valid", rsp_valid, 64'(1) << exp_w);
      check("resp_data", rsp_data, r);
      check("resp_err", rsp_err, 64'd0);
      check("resp_en", fpu_enable, 64'd0);
      check("resp_ready", req_ready, 64'd0);
      check("resp_mode_hold", fpu_mode, 64'(exp_mode));
      check("resp_op1_hold", fpu_op1, exp_op1);
      step();
      check("post_rspv", rsp_valid, 64'd0);
      check("post_busy", busy, 64'd0);
      check("post_op1_hold", fpu_op1, exp_op1);
   endtask

   initial begin
      ptr_m = 0;
      scramble_ops();

      // Reset
      rst_n = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Stray done in IDLE
      fpu_done = 1'b1;
      step();
      fpu_done = 1'b0;
      check("stray_idle_rspv", rsp_valid, 64'd0);
      check("stray_idle_state", dbg_state, 64'(ST_IDLE));
      step();
      check("stray_idle_rspv2", rsp_valid, 64'd0);

      // Contention: all four held, expect 0,1,2,3,0
      for (int t = 0; t < 5; t++) begin
         start_txn(4'b1111);
         check("contention_order", exp_w, t % N);
         finish_txn($urandom_range(0, 3), {$urandom, $urandom});
      end

      // Single request, 1.0 + 2.0 with done three cycles after enable
      mode_a[0] = MODE_ADD;
      op1_a[0]  = 64'h3FF0000000000000;
      op2_a[0]  = 64'h4000000000000000;
      start_txn(4'b0001);
      finish_txn(2, 64'h4008000000000000);

      // Randomized traffic
      for (int t = 0; t < 12; t++) begin
         scramble_ops();
         start_txn(4'($urandom_range(1, 15)));
         finish_txn($urandom_range(0, 4), {$urandom, $urandom});
      end

      // Reset mid-WAIT: requester 1 accepted (model ptr becomes 2), abandoned
      start_txn(4'b0010);
      step();
      step();
      req_valid = '0;
      rst_n = 1'b0;
      step();
      check_all_zero("midreset");
      rst_n = 1'b1;
      ptr_m = 0;
      step();
      check("midreset_no_rsp", rsp_valid, 64'd0);
      scramble_ops();
      start_txn(4'b0101);
      check("midreset_ptr0", exp_w, 0);
      finish_txn(1, {$urandom, $urandom});
      start_txn(4'b0100);
      finish_txn(0, {$urandom, $urandom});

`ifdef FPU_SCHED_TIMEOUT_EN
      // No done: response in cycle 256 after ISSUE with error
      start_txn(4'b1000);
      begin
         int k;
         k = 1;
         while (k < 256 && rsp_valid === '0) begin
            step();
            k++;
         end
         check("timeout_cycle", k, 256);
         check("timeout_valid", rsp_valid, 64'(1) << exp_w);
         check("timeout_err", rsp_err, 64'd1);
         check("timeout_data", rsp_data, 64'd0);
         step();
         check("timeout_post_busy", busy, 64'd0);
      end
      // Done in the same cycle as the limit: normal result
      start_txn(4'b0010);
      finish_txn(254, 64'h0123456789ABCDEF);
`endif

      check("one_enable_per_txn", en_cnt, txn_cnt);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
